// File: rtl/async_fifo_wr_ctrl_if.sv
// rtl/async_fifo_wr_ctrl_if.sv - write-side bundle between RX datapath, FIFO memory and read domain
interface async_fifo_wr_ctrl_if #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR       = $clog2(FIFO_DEPTH)
);
  logic            wr_en_i;
  logic            ovf_clr_i;
  logic [ADDR:0]   rd_gray_ptr_i;
  logic            wr_valid_o;
  logic [ADDR-1:0] wr_ptr_o;
  logic [ADDR:0]   wr_gray_ptr_o;
  logic            full_o;
  logic            afull_o;
  logic [ADDR:0]   wr_level_o;
  logic            overflow_o;

  // Upstream / read-domain side: issues writes, supplies the read pointer.
  modport master (
    output wr_en_i, ovf_clr_i, rd_gray_ptr_i,
    input  wr_valid_o, wr_ptr_o, wr_gray_ptr_o, full_o, afull_o, wr_level_o, overflow_o
  );

  // Controller side.
  modport slave (
    input  wr_en_i, ovf_clr_i, rd_gray_ptr_i,
    output wr_valid_o, wr_ptr_o, wr_gray_ptr_o, full_o, afull_o, wr_level_o, overflow_o
  );
endinterface

// File: rtl/async_fifo_wr_ctrl.sv
// rtl/async_fifo_wr_ctrl.sv - write-domain pointer, flag and occupancy controller for the UART async FIFO
module async_fifo_wr_ctrl #(
  parameter int DLY         = 1,
  parameter int FIFO_DEPTH  = 8,
  parameter int ADDR        = $clog2(FIFO_DEPTH),
  parameter int AFULL_LEVEL = FIFO_DEPTH - 2
) (
  input  logic                 wr_clk_i,
  input  logic                 rst_n_i,
  async_fifo_wr_ctrl_if.slave  bus
);

  // Parameter sanity; DLY only matters to behavioural models, so it is range-checked here.
  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 4");
  end
  if (AFULL_LEVEL < 1 || AFULL_LEVEL > FIFO_DEPTH || DLY < 0) begin : g_bad_level
    $error("AFULL_LEVEL must lie in 1..FIFO_DEPTH and DLY must be non-negative");
  end

  localparam logic [ADDR:0] AFULL_THR = (ADDR + 1)'(AFULL_LEVEL);

  logic          accept;
  logic [ADDR:0] wbin_q,  wbin_d;
  logic [ADDR:0] wgray_q, wgray_d;
  logic [ADDR:0] rq1_q,   rq2_q;
  logic [ADDR:0] rbin_s;
  logic [ADDR:0] level_q, level_d;
  logic          full_q,  full_d;
  logic          afull_q, afull_d;
  logic          ovf_q,   ovf_d;

  // A write is only taken when the registered full flag is clear.
  assign accept            = bus.wr_en_i & ~full_q;
  assign bus.wr_valid_o    = accept;
  assign bus.wr_ptr_o      = wbin_q[ADDR-1:0];
  assign bus.wr_gray_ptr_o = wgray_q;
  assign bus.full_o        = full_q;
  assign bus.afull_o       = afull_q;
  assign bus.wr_level_o    = level_q;
  assign bus.overflow_o    = ovf_q;

  // Next pointer, its Gray form, synchronised read pointer in binary, and next flag values.
  always_comb begin
    wbin_d  = wbin_q + {{ADDR{1'b0}}, accept};
    wgray_d = (wbin_d >> 1) ^ wbin_d;

    rbin_s       = '0;
    rbin_s[ADDR] = rq2_q[ADDR];
    for (int i = ADDR - 1; i >= 0; i--) begin
      rbin_s[i] = rbin_s[i+1] ^ rq2_q[i];
    end

    // Full is judged against the next pointer so the filling write raises it at its own edge.
    level_d = wbin_d - rbin_s;
    full_d  = (wgray_d == {~rq2_q[ADDR:ADDR-1], rq2_q[ADDR-2:0]});
    afull_d = (level_d >= AFULL_THR);

    // Set has priority over clear so a rejected write is never lost.
    ovf_d = ovf_q;
    if (bus.wr_en_i & full_q) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  // Binary and Gray write pointers advance together on an accepted write.
  always_ff @(posedge wr_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wbin_q  <= '0;
      wgray_q <= '0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
    end
  end

  // Two-flop synchroniser for the read-domain Gray pointer, nothing between the stages.
  always_ff @(posedge wr_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rq1_q <= '0;
      rq2_q <= '0;
    end else begin
      rq1_q <= bus.rd_gray_ptr_i;
      rq2_q <= rq1_q;
    end
  end

  // Registered status: full, almost-full, occupancy and sticky overflow.
  always_ff @(posedge wr_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      full_q  <= full_d;
      afull_q <= afull_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
